// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding and frame constants for the write-only I2C controller
package i2c_pkg;
  localparam int NUM_BYTES_DEF = 3;
  localparam int BITS_PER_BYTE = 8;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic PH_L = 1'b0;
  localparam logic PH_H = 1'b1;
endpackage

// File: rtl/i2c_sda_pad.sv
// i2c_sda_pad: open-drain SDA pad, drives low or releases, and returns the line level
//  drive_low_i in  : 1 pulls SDA to 0, 0 releases it to 'z'
//  sda_io      io  : the shared I2C data line
//  sda_o       out : sampled level of the line
module i2c_sda_pad (
  input  logic drive_low_i,
  inout  tri   sda_io,
  output logic sda_o
);
  assign sda_io = drive_low_i ? 1'b0 : 1'bz;
  assign sda_o  = sda_io;
endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: write-only I2C master sending one NUM_BYTES frame per accepted go
//  clk_i2c  in  : controller clock, SCL runs at half this rate
//  reset_n  in  : asynchronous active-low reset
//  go       in  : transfer request level, sampled only in IDLE and DONE
//  i2c_data in  : frame bytes, MSB byte first, latched when go is accepted
//  end_o    out : frame complete, held until go drops
//  ack      out : per-byte sampled ACK bits, ack[NUM_BYTES-1] is the first byte
//  i2c_sclk out : registered SCL
//  i2c_sdat io  : open-drain SDA
//  Macro I2C_NACK_ABORT_EN: a NACK jumps straight to STOP and marks unsent bytes as NACK.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF
) (
  input  logic                   clk_i2c,
  input  logic                   reset_n,
  input  logic                   go,
  input  logic [8*NUM_BYTES-1:0] i2c_data,
  output logic                   end_o,
  output logic [NUM_BYTES-1:0]   ack,
  output logic                   i2c_sclk,
  inout  tri                     i2c_sdat
);
  localparam int DW = BITS_PER_BYTE * NUM_BYTES;
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  logic [2:0] state_q, state_d;
  logic ph_q, ph_d;
  // bit index inside a byte while in BIT, step counter while in STOP
  logic [2:0] bit_q, bit_d;
  // counts down from the first byte, so it is directly the ack index of the current byte
  logic [BW-1:0] byte_q, byte_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [NUM_BYTES-1:0] ack_q, ack_d;
  logic scl_q, scl_d, low_q, low_d, end_q, end_d;
  logic sda_in, nack_stop;
  i2c_sda_pad u_pad (
    .drive_low_i(low_q),
    .sda_io     (i2c_sdat),
    .sda_o      (sda_in)
  );
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    bit_d = bit_q;
    byte_d = byte_q;
    sh_d = sh_q;
    ack_d = ack_q;
    scl_d = scl_q;
    low_d = low_q;
    end_d = end_q;
    nack_stop = 1'b0;
    if (state_q == S_IDLE) begin
      scl_d = 1'b1;
      low_d = 1'b0;
      end_d = 1'b0;
      if (go) begin
        state_d = S_START;
        low_d = 1'b1;
        sh_d = i2c_data;
        ack_d = '0;
        byte_d = BW'(NUM_BYTES - 1);
        bit_d = '0;
      end
    end else if (state_q == S_START) begin
      state_d = S_BIT;
      ph_d = PH_L;
      scl_d = 1'b0;
      low_d = ~sh_q[DW-1];
    end else if (state_q == S_BIT && ph_q == PH_L) begin
      ph_d = PH_H;
      scl_d = 1'b1;
    end else if (state_q == S_BIT) begin
      // shift after every bit so the next bit to send is always at DW-1
      sh_d = sh_q << 1;
      ph_d = PH_L;
      scl_d = 1'b0;
      bit_d = bit_q + 3'd1;
      low_d = (bit_q == 3'd7) ? 1'b0 : ~sh_q[DW-2];
      state_d = (bit_q == 3'd7) ? S_ACK : S_BIT;
    end else if (state_q == S_ACK && ph_q == PH_L) begin
      ph_d = PH_H;
      scl_d = 1'b1;
    end else if (state_q == S_ACK) begin
      ack_d[byte_q] = sda_in;
      ph_d = PH_L;
      scl_d = 1'b0;
`ifdef I2C_NACK_ABORT_EN
      nack_stop = sda_in;
      if (sda_in) ack_d = ack_d | ((NUM_BYTES'(1) << byte_q) - NUM_BYTES'(1));
`else
      nack_stop = 1'b0;
`endif
      if (byte_q == '0 || nack_stop) begin
        state_d = S_STOP;
        bit_d = '0;
        low_d = 1'b1;
      end else begin
        state_d = S_BIT;
        byte_d = byte_q - 1'b1;
        low_d = ~sh_q[DW-1];
      end
    end else if (state_q == S_STOP) begin
      // step 0 -> SCL high with SDA low, step 1 -> SDA release (stop edge), step 2 -> DONE
      bit_d = bit_q + 3'd1;
      scl_d = 1'b1;
      low_d = (bit_q == 3'd0);
      state_d = (bit_q == 3'd2) ? S_DONE : S_STOP;
      end_d = (bit_q == 3'd2);
    end else if (!go) begin
      state_d = S_IDLE;
      end_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q <= PH_L;
      bit_q <= '0;
      byte_q <= '0;
      sh_q <= '0;
      ack_q <= '0;
      scl_q <= 1'b1;
      low_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      sh_q <= sh_d;
      ack_q <= ack_d;
      scl_q <= scl_d;
      low_q <= low_d;
      end_q <= end_d;
    end
  end
  assign end_o = end_q;
  assign ack = ack_q;
  assign i2c_sclk = scl_q;
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: randomized bench for i2c_controller with a cycle-indexed frame model and a bus-level slave
module tb_i2c_controller;
  logic clk_i2c = 1'b0;
  logic reset_n, go, end_o, i2c_sclk;
  logic [23:0] i2c_data;
  logic [2:0] ack;
  tri i2c_sdat;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, e0 = 0, lat = 0, end_rises = 0;
  bit run = 0;
  always #5 clk_i2c = ~clk_i2c;
  always @(posedge clk_i2c) cyc++;
  always @(posedge end_o) end_rises++;
  i2c_controller dut (
    .clk_i2c (clk_i2c),
    .reset_n (reset_n),
    .go      (go),
    .i2c_data(i2c_data),
    .end_o   (end_o),
    .ack     (ack),
    .i2c_sclk(i2c_sclk),
    .i2c_sdat(i2c_sdat)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // slave: pull-up line, ACKs byte b unless slv_nack[b], decodes bytes between start and stop
  logic [2:0] slv_nack = 3'b000;
  logic s_low = 1'b0;
  bit s_ackph = 0;
  int s_rises = 0, s_byte = 0;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_dec [3];
  logic [7:0] s_last [3];
  pullup (i2c_sdat);
  assign i2c_sdat = s_low ? 1'b0 : 1'bz;
  always @(negedge reset_n) begin
    s_low = 1'b0;
    s_ackph = 0;
  end
  always @(negedge i2c_sdat) if (i2c_sclk === 1'b1) begin
    s_rises = 0;
    s_byte = 0;
    s_ackph = 0;
  end
  always @(posedge i2c_sclk) if (!s_ackph && s_rises < 8) begin
    s_sh = {s_sh[6:0], i2c_sdat};
    s_rises++;
    if (s_rises == 8 && s_byte < 3) s_dec[s_byte] = s_sh;
  end
  always @(negedge i2c_sclk) begin
    if (s_rises == 8 && !s_ackph) begin
      s_ackph = 1;
      s_low = (s_byte < 3) ? !slv_nack[s_byte] : 1'b0;
    end else if (s_ackph) begin
      s_ackph = 0;
      s_low = 1'b0;
      s_rises = 0;
      s_byte++;
    end
  end
  // model: one frame = start, 18 cycles per byte, 3 stop cycles, then DONE
  bit m_busy = 0;
  int m_k = 0, m_nb = 3, m_done = 0;
  logic [23:0] m_data = '0;
  logic [2:0] m_nack = '0, m_ack = '0;
  always @(posedge i2c_sdat) if (reset_n && run && i2c_sclk === 1'b1) begin
    chk("dec_cnt", s_byte, m_nb);
    for (int b = 0; b < 3; b++) begin
      if (b < m_nb) chk("dec_byte", s_dec[b], m_data[23-8*b -: 8]);
      s_last[b] = s_dec[b];
    end
  end
  always @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0;
      m_k = 0;
      m_ack = '0;
    end else if (!m_busy) begin
      if (go) begin
        m_busy = 1;
        m_k = 0;
        m_data = i2c_data;
        m_nack = slv_nack;
        m_ack = '0;
        m_nb = 3;
`ifdef I2C_NACK_ABORT_EN
        for (int b = 2; b >= 0; b--) if (slv_nack[b]) m_nb = b + 1;
`endif
      end
    end else if (m_k >= 18 * m_nb + 4) begin
      if (!go) m_busy = 0;
    end else begin
      m_k++;
      if (m_k >= 19 && m_k <= 18 * m_nb + 1 && m_k % 18 == 1) begin
        m_ack[2 - (m_k / 18 - 1)] = m_nack[m_k / 18 - 1];
        if (m_k / 18 == m_nb) for (int j = m_nb; j < 3; j++) m_ack[2 - j] = 1'b1;
      end
      if (m_k == 18 * m_nb + 4) m_done++;
    end
  end
  always @(negedge clk_i2c) if (reset_n && run) begin
    int s, j, b, r;
    logic es, ed, ee;
    s = 18 * m_nb;
    es = 1'b1;
    ed = 1'b1;
    ee = 1'b0;
    if (m_busy) begin
      if (m_k == 0) ed = 1'b0;
      else if (m_k <= s) begin
        j = m_k - 1;
        b = j / 18;
        r = j % 18;
        es = (r % 2 == 1);
        ed = (r < 16) ? m_data[23 - 8 * b - r / 2] : m_nack[b];
      end else if (m_k == s + 1) begin
        es = 1'b0;
        ed = 1'b0;
      end else if (m_k == s + 2) ed = 1'b0;
      else if (m_k >= s + 4) ee = 1'b1;
    end
    chk("scl", i2c_sclk, es);
    chk("sda", i2c_sdat, ed);
    chk("end", end_o, ee);
    chk("ack", ack, m_ack);
  end
  task automatic launch(input logic [23:0] d, input logic [2:0] nk);
    i2c_data = d;
    slv_nack = nk;
    go = 1'b1;
    e0 = cyc + 1;
  endtask
  task automatic wait_end();
    int n = 0;
    while (end_o !== 1'b1 && n < 300) begin
      @(negedge clk_i2c);
      n++;
    end
    chk("end_seen", end_o, 1);
    lat = cyc - e0;
  endtask
  task automatic finish_frame(input int hold);
    repeat (hold) @(negedge clk_i2c);
    go = 1'b0;
    repeat (2) @(negedge clk_i2c);
  endtask
  initial begin
    reset_n = 1'b0;
    go = 1'b0;
    i2c_data = '0;
    repeat (3) @(negedge clk_i2c);
    reset_n = 1'b1;
    run = 1;
    @(negedge clk_i2c);
    chk("rst_scl", i2c_sclk, 1);
    chk("rst_sda", i2c_sdat, 1);
    chk("rst_end", end_o, 0);
    chk("rst_ack", ack, 0);
    launch(24'h341E00, 3'b000);
    wait_end();
    chk("latency", lat, 58);
    chk("ack_all", ack, 3'b000);
    chk("byte0", s_last[0], 8'h34);
    chk("byte1", s_last[1], 8'h1E);
    chk("byte2", s_last[2], 8'h00);
    repeat (5) @(negedge clk_i2c);
    chk("end_hold", end_o, 1);
    go = 1'b0;
    @(negedge clk_i2c);
    chk("drop_end", end_o, 0);
    chk("drop_scl", i2c_sclk, 1);
    chk("drop_sda", i2c_sdat, 1);
    @(negedge clk_i2c);
    launch(24'h340C00, 3'b010);
    wait_end();
`ifdef I2C_NACK_ABORT_EN
    chk("ack_nack", ack, 3'b011);
`else
    chk("ack_nack", ack, 3'b010);
`endif
    finish_frame(0);
    launch($urandom, 3'b000);
    while (cyc < e0 + 20) @(negedge clk_i2c);
    reset_n = 1'b0;
    go = 1'b0;
    #1;
    chk("mid_rst_scl", i2c_sclk, 1);
    chk("mid_rst_sda", i2c_sdat, 1);
    chk("mid_rst_end", end_o, 0);
    chk("mid_rst_ack", ack, 0);
    repeat (2) @(negedge clk_i2c);
    reset_n = 1'b1;
    @(negedge clk_i2c);
    launch(24'h34A55A, 3'b000);
    wait_end();
    chk("fresh_latency", lat, 58);
    finish_frame(1);
    for (int i = 0; i < 9; i++) begin
      launch({8'h34, 8'h0F - 8'(i), 8'($urandom)},
             ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
      wait_end();
      finish_frame($urandom_range(0, 3));
    end
    launch(24'h34C3_81, 3'b000);
    repeat (10) @(negedge clk_i2c);
    i2c_data = $urandom;
    go = 1'b0;
    repeat (7) @(negedge clk_i2c);
    go = 1'b1;
    i2c_data = $urandom;
    repeat (5) @(negedge clk_i2c);
    go = 1'b0;
    repeat (3) @(negedge clk_i2c);
    go = 1'b1;
    wait_end();
    chk("mid_chg_latency", lat, 58);
    finish_frame(0);
    chk("end_rises", end_rises, m_done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
